// File: rtl/sv32_page_walker.sv
// Sv32 hardware page-table walker: two-level walk over ArmleoBus single-word reads.
// Result and fault outputs are combinational and valid only in the resolve_done cycle.
module sv32_page_walker (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        resolve_request,
    input  logic [19:0] virtual_address,
    output logic        resolve_ack,
    output logic        resolve_done,
    output logic        resolve_pagefault,
    output logic        resolve_accessfault,
    output logic [7:0]  resolve_access_bits,
    output logic [21:0] resolve_physical_address,

    input  logic        satp_mode,
    input  logic [21:0] satp_ppn,

    output logic        m_transaction,
    output logic [2:0]  m_cmd,
    output logic [33:0] m_address,
    input  logic [2:0]  m_transaction_response,
    input  logic        m_transaction_done,
    input  logic [31:0] m_rdata
);

    localparam int unsigned VPN_W  = 20;
    localparam int unsigned VPNI_W = 10;
    localparam int unsigned PPN_W  = 22;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_READ   = 3'd1;
    localparam logic [2:0] RESP_OKAY  = 3'd0;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [VPN_W-1:0]    r_vpn;
    logic [PPN_W-1:0]    r_table_ppn;
    logic                r_level;

    logic                w_accept;
    logic                w_descend;
    logic [VPNI_W-1:0]   w_vpn_sel;

    logic                w_pte_v;
    logic                w_pte_r;
    logic                w_pte_w;
    logic                w_pte_x;
    logic                w_pte_invalid;
    logic                w_pte_leaf;
    logic                w_pte_misaligned;
    logic                w_unused_rsw;

    // PTE field decode of the word currently on the read bus
    assign w_pte_v          = m_rdata[0];
    assign w_pte_r          = m_rdata[1];
    assign w_pte_w          = m_rdata[2];
    assign w_pte_x          = m_rdata[3];
    assign w_pte_invalid    = !w_pte_v || (w_pte_w && !w_pte_r);
    assign w_pte_leaf       = w_pte_r || w_pte_x;
    assign w_pte_misaligned = (m_rdata[19:10] != 10'd0);
    assign w_unused_rsw     = ^m_rdata[9:8];

    assign w_vpn_sel = r_level ? r_vpn[19:10] : r_vpn[9:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_vpn       <= '0;
            r_table_ppn <= '0;
            r_level     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_vpn       <= virtual_address;
                r_table_ppn <= satp_ppn;
                r_level     <= 1'b1;
            end else if (w_descend) begin
                r_table_ppn <= m_rdata[31:10];
                r_level     <= 1'b0;
            end
        end
    end

    // Everything is gated by rst_n so a reset mid-walk drops the bus at once
    always_comb begin
        w_state_nxt              = r_state;
        w_accept                 = 1'b0;
        w_descend                = 1'b0;
        resolve_ack              = 1'b0;
        resolve_done             = 1'b0;
        resolve_pagefault        = 1'b0;
        resolve_accessfault      = 1'b0;
        resolve_access_bits      = 8'h00;
        resolve_physical_address = '0;
        m_transaction            = 1'b0;
        m_cmd                    = CMD_NONE;
        m_address                = '0;

        case (r_state)
            IDLE: begin
                if (rst_n && resolve_request) begin
                    resolve_ack = 1'b1;
                    if (satp_mode) begin
                        w_accept    = 1'b1;
                        w_state_nxt = WALK;
                    end else begin
                        resolve_done             = 1'b1;
                        resolve_access_bits      = 8'hFF;
                        resolve_physical_address = {2'b00, virtual_address};
                    end
                end
            end
            WALK: begin
                if (rst_n) begin
                    m_transaction = 1'b1;
                    m_cmd         = CMD_READ;
                    m_address     = {r_table_ppn, w_vpn_sel, 2'b00};
                    if (m_transaction_done) begin
                        w_state_nxt = IDLE;
                        if (m_transaction_response != RESP_OKAY) begin
                            resolve_done        = 1'b1;
                            resolve_accessfault = 1'b1;
                        end else if (w_pte_invalid) begin
                            resolve_done      = 1'b1;
                            resolve_pagefault = 1'b1;
                        end else if (w_pte_leaf) begin
                            resolve_done = 1'b1;
                            if (r_level && w_pte_misaligned) begin
                                resolve_pagefault = 1'b1;
                            end else begin
                                resolve_access_bits      = m_rdata[7:0];
                                resolve_physical_address = r_level ? {m_rdata[31:20], r_vpn[9:0]}
                                                                   : m_rdata[31:10];
                            end
                        end else if (!r_level) begin
                            resolve_done      = 1'b1;
                            resolve_pagefault = 1'b1;
                        end else begin
                            w_descend   = 1'b1;
                            w_state_nxt = WALK;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sv32_page_walker.sv
// Scoreboard bench for sv32_page_walker: sparse page-table memory, bus responder
// with random latency, and a walk model evaluated straight from the Sv32 rules.
module tb_sv32_page_walker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        resolve_request;
    logic [19:0] virtual_address;
    logic        resolve_ack;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [7:0]  resolve_access_bits;
    logic [21:0] resolve_physical_address;
    logic        satp_mode;
    logic [21:0] satp_ppn;
    logic        m_transaction;
    logic [2:0]  m_cmd;
    logic [33:0] m_address;
    logic [2:0]  m_transaction_response;
    logic        m_transaction_done;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    sv32_page_walker dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .resolve_request          (resolve_request),
        .virtual_address          (virtual_address),
        .resolve_ack              (resolve_ack),
        .resolve_done             (resolve_done),
        .resolve_pagefault        (resolve_pagefault),
        .resolve_accessfault      (resolve_accessfault),
        .resolve_access_bits      (resolve_access_bits),
        .resolve_physical_address (resolve_physical_address),
        .satp_mode                (satp_mode),
        .satp_ppn                 (satp_ppn),
        .m_transaction            (m_transaction),
        .m_cmd                    (m_cmd),
        .m_address                (m_address),
        .m_transaction_response   (m_transaction_response),
        .m_transaction_done       (m_transaction_done),
        .m_rdata                  (m_rdata)
    );

    typedef struct {
        logic        af;
        logic        pf;
        logic [7:0]  bits;
        logic [21:0] phys;
        int          nreads;
        logic [33:0] a0;
        logic [33:0] a1;
    } exp_t;

    // {X,W,R} leaf permission patterns
    localparam logic [2:0] PERMS [5] = '{3'b001, 3'b011, 3'b100, 3'b101, 3'b111};

    exp_t        exp_q [$];
    logic [33:0] rd_log [$];
    logic [31:0] mem [longint];
    bit          err_map [longint];
    int          total = 0;
    int          bad   = 0;
    bit          hold_bus = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Walk the table in plain byte-address arithmetic
    function automatic exp_t model(input logic mode, input logic [21:0] ppn, input logic [19:0] va);
        exp_t        e;
        longint      tbl;
        longint      addr;
        logic [31:0] pte;
        int          lvl;
        logic [9:0]  idx;
        bit          fin;
        e = '{default: 0};
        if (!mode) begin
            e.bits = 8'hFF;
            e.phys = {2'b00, va};
            return e;
        end
        tbl = longint'(ppn);
        lvl = 1;
        fin = 1'b0;
        while (!fin) begin
            idx  = (lvl == 1) ? va[19:10] : va[9:0];
            addr = tbl * 4096 + longint'(idx) * 4;
            if (e.nreads == 0) e.a0 = 34'(addr);
            else               e.a1 = 34'(addr);
            e.nreads++;
            fin = 1'b1;
            pte = mem.exists(addr) ? mem[addr] : 32'h0;
            if (err_map.exists(addr)) begin
                e.af = 1'b1;
            end else if (!pte[0] || (pte[2] && !pte[1])) begin
                e.pf = 1'b1;
            end else if (pte[1] || pte[3]) begin
                if (lvl == 1 && pte[19:10] != 10'd0) begin
                    e.pf = 1'b1;
                end else begin
                    e.bits = pte[7:0];
                    e.phys = (lvl == 1) ? 22'(longint'(pte[31:20]) * 1024 + longint'(va[9:0]))
                                        : pte[31:10];
                end
            end else if (lvl == 0) begin
                e.pf = 1'b1;
            end else begin
                tbl = longint'(pte[31:10]);
                lvl = 0;
                fin = 1'b0;
            end
        end
        return e;
    endfunction

    // k: 1 invalid, 2 aligned leaf, 3 misaligned leaf, 4 pointer
    function automatic logic [31:0] gen_pte(input int k);
        logic [31:0] r;
        r = $urandom;
        case (k)
            1: if ($urandom_range(0, 1) == 0) r[0] = 1'b0; else r[3:0] = 4'b0101;
            2: begin r[3:1] = PERMS[$urandom_range(0, 4)]; r[0] = 1'b1; r[19:10] = 10'd0; end
            3: begin r[3:1] = PERMS[$urandom_range(0, 4)]; r[0] = 1'b1; r[10] = 1'b1; end
            default: begin r[31:10] = 22'($urandom_range(0, 3)); r[3:0] = 4'b0001; end
        endcase
        return r;
    endfunction

    // Bus responder: random 0..2 wait cycles, data and errors from the memory map
    initial begin
        int     dly;
        longint a;
        dly = 0;
        m_transaction_done     = 1'b0;
        m_transaction_response = 3'd0;
        m_rdata                = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            m_transaction_done     = 1'b0;
            m_transaction_response = 3'd0;
            m_rdata                = 32'h0;
            if (rst_n && m_transaction && !hold_bus) begin
                if (dly == 0) begin
                    a = longint'(m_address);
                    check("m_cmd_read", 64'(m_cmd), 64'd1);
                    rd_log.push_back(m_address);
                    m_transaction_done     = 1'b1;
                    m_rdata                = mem.exists(a) ? mem[a] : 32'h0;
                    m_transaction_response = err_map.exists(a) ? 3'($urandom_range(1, 7)) : 3'd0;
                    dly = $urandom_range(0, 2);
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: every done pops one expectation and the reads logged since the last one
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resolve_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("accessfault", 64'(resolve_accessfault), 64'(e.af));
                    check("pagefault", 64'(resolve_pagefault), 64'(e.pf));
                    if (!e.af && !e.pf) begin
                        check("access_bits", 64'(resolve_access_bits), 64'(e.bits));
                        check("physical", 64'(resolve_physical_address), 64'(e.phys));
                    end
                    check("nreads", 64'(rd_log.size()), 64'(e.nreads));
                    if (e.nreads > 0 && rd_log.size() > 0) check("addr0", 64'(rd_log[0]), 64'(e.a0));
                    if (e.nreads > 1 && rd_log.size() > 1) check("addr1", 64'(rd_log[1]), 64'(e.a1));
                end
                rd_log.delete();
            end
        end
    end

    task automatic run_walk(input logic mode, input logic [21:0] ppn, input logic [19:0] va, input int n);
        int seen;
        int cyc;
        for (int i = 0; i < n; i++) exp_q.push_back(model(mode, ppn, va));
        @(posedge clk);
        #2;
        satp_mode       = mode;
        satp_ppn        = ppn;
        virtual_address = va;
        resolve_request = 1'b1;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < 200) begin
            @(negedge clk);
            if (resolve_done) seen++;
            cyc++;
        end
        if (seen < n) begin
            check("walk_timeout", 64'(seen), 64'(n));
            exp_q.delete();
            rd_log.delete();
        end
        @(posedge clk);
        #2;
        resolve_request = 1'b0;
    endtask

    task automatic clear_mem();
        mem.delete();
        err_map.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        mode;
        logic [21:0] ppn;
        logic [19:0] va;
        logic [31:0] pte;
        longint      ra;
        longint      ca;
        int          k;
        int          cyc;
        logic [31:0] bad_ptes [3];
        bad_ptes = '{32'h0, 32'h5, 32'hD};

        rst_n           = 1'b0;
        resolve_request = 1'b0;
        virtual_address = 20'h0;
        satp_mode       = 1'b1;
        satp_ppn        = 22'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_transaction", 64'(m_transaction), 64'd0);
        check("rst_m_cmd", 64'(m_cmd), 64'd0);
        check("rst_ack", 64'(resolve_ack), 64'd0);
        check("rst_done", 64'(resolve_done), 64'd0);
        check("rst_faults", 64'({resolve_pagefault, resolve_accessfault}), 64'd0);
        check("rst_data", 64'({resolve_access_bits, resolve_physical_address}), 64'd0);
        resolve_request = 1'b1;
        satp_mode       = 1'b0;
        @(negedge clk);
        check("rst_req_ack", 64'(resolve_ack), 64'd0);
        check("rst_req_done", 64'(resolve_done), 64'd0);
        resolve_request = 1'b0;
        satp_mode       = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        clear_mem(); err_map[4] = 1'b1;
        run_walk(1'b1, 22'h0, {10'd1, 10'd0}, 1);

        clear_mem(); mem[4] = 32'h401; err_map[32'h1000] = 1'b1;
        run_walk(1'b1, 22'h0, {10'd1, 10'd0}, 1);

        for (int i = 0; i < 5; i++) begin
            clear_mem();
            mem[longint'(4 * (3 + i))] = 32'h40000000 | 32'({PERMS[i], 1'b1});
            run_walk(1'b1, 22'h0, {10'(3 + i), 10'd0}, 1);
        end

        clear_mem(); mem[8] = 32'h4000040F;
        run_walk(1'b1, 22'h0, {10'd2, 10'd0}, 1);

        for (int i = 0; i < 3; i++) begin
            clear_mem(); mem[longint'(4 * (8 + i))] = bad_ptes[i];
            run_walk(1'b1, 22'h0, {10'(8 + i), 10'd0}, 1);
        end

        for (int i = 0; i < 3; i++) begin
            clear_mem(); mem[4] = 32'h401; mem[longint'(32'h1000 + 4 * (6 + i))] = bad_ptes[i];
            run_walk(1'b1, 22'h0, {10'd1, 10'(6 + i)}, 1);
        end

        clear_mem(); mem[4] = 32'h401; mem[32'h1000] = 32'h801;
        run_walk(1'b1, 22'h0, {10'd1, 10'd0}, 1);

        clear_mem(); mem[4] = 32'h401; mem[32'h1014] = 32'h123450CF;
        run_walk(1'b1, 22'h0, {10'd1, 10'd5}, 1);

        clear_mem();
        run_walk(1'b0, 22'h0, 20'hABCDE, 1);

        clear_mem(); mem[32'h200C] = 32'h0080_00CB;
        run_walk(1'b1, 22'h2, {10'd3, 10'h155}, 2);

        // Reset in the middle of a walk
        clear_mem(); mem[4] = 32'h401; hold_bus = 1'b1;
        @(posedge clk);
        #2;
        satp_mode = 1'b1; satp_ppn = 22'h0; virtual_address = {10'd1, 10'd0}; resolve_request = 1'b1;
        cyc = 0;
        while (!m_transaction && cyc < 20) begin @(negedge clk); cyc++; end
        check("abort_walk_started", 64'(m_transaction), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0; resolve_request = 1'b0;
        #1;
        check("abort_txn_drop", 64'(m_transaction), 64'd0);
        check("abort_cmd_none", 64'(m_cmd), 64'd0);
        @(negedge clk);
        check("abort_no_done", 64'(resolve_done), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1; hold_bus = 1'b0; rd_log.delete();
        @(negedge clk);
        check("abort_idle", 64'(m_transaction), 64'd0);

        for (int it = 0; it < 40; it++) begin
            clear_mem();
            mode = ($urandom_range(0, 7) != 0);
            ppn  = 22'($urandom_range(0, 3));
            va   = 20'($urandom);
            ra   = longint'(ppn) * 4096 + longint'(va[19:10]) * 4;
            k    = $urandom_range(0, 4);
            if (k == 0) err_map[ra] = 1'b1;
            else        mem[ra] = gen_pte(k);
            if (k == 4) begin
                pte = mem[ra];
                ca  = longint'(pte[31:10]) * 4096 + longint'(va[9:0]) * 4;
                k   = $urandom_range(0, 4);
                if (k == 0) err_map[ca] = 1'b1;
                else        mem[ca] = gen_pte(k);
            end
            run_walk(mode, ppn, va, $urandom_range(1, 2));
        end

        repeat (5) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
